// File: rtl/snn_seq_pkg.sv
// Shared constants and state encoding for the LIF time-step sequencer.
package snn_seq_pkg;

  localparam int W5    = 5;
  localparam int ACC_W = 9;

  localparam logic [5:0] ADDR_THR = 6'd32;
  localparam logic [5:0] ADDR_DEC = 6'd33;
  localparam logic [5:0] ADDR_REF = 6'd34;

  localparam logic [4:0] THR_RST = 5'd8;
  localparam logic [2:0] DEC_RST = 3'd1;
  localparam logic [4:0] REF_RST = 5'd2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCUM   = 3'd1,
    ST_FIRE    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } seq_state_t;

endpackage

// File: rtl/lif_step_sequencer_sat_clamp5.sv
// Saturating clamp of a 9-bit signed accumulator into the 5-bit signed
// neuron current range [-16, +15].
module sat_clamp5
  import snn_seq_pkg::*;
(
  input  logic signed [ACC_W-1:0] din,
  output logic signed [W5-1:0]    dout
);

  localparam logic signed [ACC_W-1:0] MAX_V = 9'sd15;
  localparam logic signed [ACC_W-1:0] MIN_V = -9'sd16;

  // Saturate above +15 and below -16, pass the low bits through otherwise
  always_comb begin
    if (din > MAX_V) begin
      dout = 5'sd15;
    end else if (din < MIN_V) begin
      dout = 5'b10000;
    end else begin
      dout = din[W5-1:0];
    end
  end

endmodule

// File: rtl/lif_step_sequencer.sv
// Time-step sequencer: accumulates weighted input spikes per neuron, fires the
// attached LIF neurons for one cycle and captures their spike outputs.
module lif_step_sequencer
  import snn_seq_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int N_OUT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [N_IN-1:0]       in_spikes,
  output logic                  busy,
  output logic                  done,
  output logic [N_OUT-1:0]      out_spikes,
  input  logic                  cfg_we,
  input  logic [5:0]            cfg_addr,
  input  logic [4:0]            cfg_wdata,
  output logic [N_OUT-1:0]      nrn_enable,
  output logic [N_OUT*W5-1:0]   nrn_current,
  output logic [4:0]            nrn_threshold,
  output logic [2:0]            nrn_decay,
  output logic [4:0]            nrn_refractory,
  input  logic [N_OUT-1:0]      nrn_spike
);

  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int N_W   = N_OUT * N_IN;

  seq_state_t              state_r;
  seq_state_t              state_next_s;
  logic [IDX_W-1:0]        idx_r;
  logic [N_IN-1:0]         spikes_r;
  logic signed [ACC_W-1:0] acc_r [N_OUT];
  logic [W5-1:0]           w_r [N_W];
  logic [4:0]              thr_r;
  logic [2:0]              dec_r;
  logic [4:0]              ref_r;
  logic [N_OUT-1:0]        out_r;
  logic                    busy_s, done_s, enable_s;
  logic                    busy_r, done_r, enable_r;
  logic                    last_idx_s;
  logic                    spike_sel_s;
  logic [W5-1:0]           wsel_s [N_OUT];

  assign last_idx_s = (idx_r == IDX_W'(N_IN - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_ACCUM;
        else       state_next_s = ST_IDLE;
      end
      ST_ACCUM: begin
        if (last_idx_s) state_next_s = ST_FIRE;
        else            state_next_s = ST_ACCUM;
      end
      ST_FIRE:    state_next_s = ST_CAPTURE;
      ST_CAPTURE: state_next_s = ST_DONE;
      ST_DONE:    state_next_s = ST_IDLE;
      default:    state_next_s = ST_IDLE;
    endcase
  end

  // Status decode from the next state so the flags come straight out of flops
  always_comb begin
    busy_s   = (state_next_s != ST_IDLE);
    done_s   = (state_next_s == ST_DONE);
    enable_s = (state_next_s == ST_FIRE);
  end

  // Status flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      enable_r <= 1'b0;
    end else begin
      busy_r   <= busy_s;
      done_r   <= done_s;
      enable_r <= enable_s;
    end
  end

  // Select the latched spike bit and each neuron's weight for the current idx
  always_comb begin
    spike_sel_s = 1'b0;
    for (int j = 0; j < N_OUT; j++) begin
      wsel_s[j] = {W5{1'b0}};
    end
    for (int i = 0; i < N_IN; i++) begin
      spike_sel_s = spike_sel_s | (spikes_r[i] & (idx_r == IDX_W'(i)));
      for (int j = 0; j < N_OUT; j++) begin
        wsel_s[j] = wsel_s[j] | (w_r[j*N_IN+i] & {W5{idx_r == IDX_W'(i)}});
      end
    end
  end

  // Step datapath: latch inputs, accumulate weights, capture neuron spikes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_r    <= {IDX_W{1'b0}};
      spikes_r <= {N_IN{1'b0}};
      out_r    <= {N_OUT{1'b0}};
      for (int j = 0; j < N_OUT; j++) begin
        acc_r[j] <= 9'sd0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            spikes_r <= in_spikes;
            idx_r    <= {IDX_W{1'b0}};
            for (int j = 0; j < N_OUT; j++) begin
              acc_r[j] <= 9'sd0;
            end
          end
        end
        ST_ACCUM: begin
          idx_r <= idx_r + IDX_W'(1);
          if (spike_sel_s) begin
            for (int j = 0; j < N_OUT; j++) begin
              acc_r[j] <= acc_r[j] + ACC_W'($signed(wsel_s[j]));
            end
          end
        end
        ST_CAPTURE: out_r <= nrn_spike;
        default: begin
        end
      endcase
    end
  end

  // Configuration registers, writable only while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < N_W; k++) begin
        w_r[k] <= {W5{1'b0}};
      end
      thr_r <= THR_RST;
      dec_r <= DEC_RST;
      ref_r <= REF_RST;
    end else if (cfg_we && !busy_r) begin
      for (int k = 0; k < N_W; k++) begin
        if (cfg_addr == 6'(k)) w_r[k] <= cfg_wdata;
      end
      if (cfg_addr == ADDR_THR) thr_r <= cfg_wdata;
      if (cfg_addr == ADDR_DEC) dec_r <= cfg_wdata[2:0];
      if (cfg_addr == ADDR_REF) ref_r <= cfg_wdata;
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_clamp
    sat_clamp5 u_clamp (
      .din  (acc_r[j]),
      .dout (nrn_current[W5*j +: W5])
    );
  end

  assign busy           = busy_r;
  assign done           = done_r;
  assign nrn_enable     = {N_OUT{enable_r}};
  assign out_spikes     = out_r;
  assign nrn_threshold  = thr_r;
  assign nrn_decay      = dec_r;
  assign nrn_refractory = ref_r;

endmodule

// File: doc/lif_step_sequencer.md
LIF_STEP_SEQUENCER -- requirements
Module: lif_step_sequencer

Interface
REQ-001 SHALL have parameter N_IN, default 8, meaning the number of input spike lines per time step.
REQ-002 SHALL have parameter N_OUT, default 4, meaning the number of attached LIF neuron instances.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: requests one time step; honoured only in IDLE.
REQ-006 SHALL have port in_spikes, input, N_IN bits: input spike vector, latched when start is accepted.
REQ-007 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse marking step completion.
REQ-009 SHALL have port out_spikes, output, N_OUT bits: captured neuron spikes of the last step.
REQ-010 SHALL have port cfg_we, input, 1 bit: configuration write strobe.
REQ-011 SHALL have port cfg_addr, input, 6 bits: configuration address.
REQ-012 SHALL have port cfg_wdata, input, 5 bits: configuration write data.
REQ-013 SHALL have port nrn_enable, output, N_OUT bits: enable to each neuron.
REQ-014 SHALL have port nrn_current, output, N_OUT*5 bits: signed 5-bit input current per neuron; neuron j occupies bits [5j+4:5j].
REQ-015 SHALL have port nrn_threshold, output, 5 bits: shared threshold.
REQ-016 SHALL have port nrn_decay, output, 3 bits: shared decay code.
REQ-017 SHALL have port nrn_refractory, output, 5 bits: shared refractory period.
REQ-018 SHALL have port nrn_spike, input, N_OUT bits: neuron spike_out lines.

Function
REQ-019 SHALL implement states IDLE, ACCUM, FIRE, CAPTURE, DONE.
REQ-020 SHALL move IDLE->ACCUM when start=1, latch in_spikes, zero all accumulators and set idx=0.
REQ-021 SHALL, in ACCUM, add signed weight w[j][idx] to accumulator j for all j in parallel when latched spike idx=1.
REQ-022 SHALL increment idx each ACCUM cycle and go to FIRE after idx=N_IN-1 (exactly N_IN ACCUM cycles).
REQ-023 SHALL use 9-bit signed accumulators, which cannot overflow (range -128..120).
REQ-024 SHALL drive nrn_current combinationally from the accumulators, each clamped to [-16,+15].
REQ-025 SHALL hold nrn_current stable through FIRE.
REQ-026 SHALL drive nrn_enable all-ones only while in FIRE (one cycle), else zero.
REQ-027 SHALL go FIRE->CAPTURE->DONE and sample nrn_spike into out_spikes at the end of the CAPTURE cycle.
REQ-028 SHALL assert done only in DONE, then return to IDLE; with start at edge 0, nrn_enable is high in cycle 9 and done in cycle 11 (N_IN=8).
REQ-029 SHALL hold out_spikes until the next CAPTURE.
REQ-030 SHALL ignore start in any state except IDLE; a start in the DONE cycle is dropped.
REQ-031 SHALL store config registers as: address j*N_IN+i holds w[j][i] (5-bit signed); address 32 holds threshold; 33 holds decay (low 3 bits); 34 holds refractory.
REQ-032 SHALL perform a config write only when cfg_we=1 and busy=0; writes while busy or to unmapped addresses are dropped with no side effect.
REQ-033 SHALL drive nrn_threshold, nrn_decay and nrn_refractory directly from the config registers.

Reset
REQ-034 SHALL, on reset, immediately force state=IDLE, busy=0, done=0, out_spikes=0, nrn_enable=0, accumulators=0 and idx=0.
REQ-035 SHALL reset config registers to weights=0, threshold=8, decay=1 and refractory=2.
REQ-036 SHALL abort a step in progress on reset mid-operation, with no done pulse and no further nrn_enable.

Structure
REQ-037 SHALL place state encodings, config address constants (THR=32, DEC=33, REF=34) and the 5-bit width constant in shared package snn_seq_pkg.
REQ-038 SHALL instantiate one sub-module, sat_clamp5 (9-bit signed to 5-bit saturating clamp), once per neuron.

Verification
REQ-039 Timing: start at edge 0 with in_spikes=8'hFF -> nrn_enable=1111 in cycle 9 only; done in cycle 11 only; busy high cycles 1-11.
REQ-040 Saturation: w[0][*]=3, w[1][*]=-16, w[2][*]=0, in_spikes=8'hFF -> nrn_current in FIRE = +15, -16, 0 for neurons 0, 1, 2.
REQ-041 Selective sum: w[3][i]=i-4, in_spikes=8'b1010_0001 -> neuron-3 current = -4+1+3 = 0; with in_spikes=8'h80, current = 3.
REQ-042 Capture: nrn_spike=0101 held only in the CAPTURE cycle -> out_spikes=0101 at done; nrn_spike pulses in other cycles are not captured.
REQ-043 Protocol: start pulses at cycles 3 and 11 of a running step -> both ignored; a cfg write of threshold=5 while busy -> nrn_threshold stays 8.
REQ-044 Reset: reset asserted in cycle 4 of ACCUM -> all outputs 0 at once; no done; the next start runs a full, normal step.
